// File: rtl/fir_pkg.sv
// Shared constants and FSM encoding for the Wishbone-to-FIR bridge.
package fir_pkg;

  localparam logic [31:0] FIR_BASE = 32'h3000_0000;

  localparam logic [7:0] OFS_CTRL = 8'h00;
  localparam logic [7:0] OFS_LEN  = 8'h10;
  localparam logic [7:0] OFS_X    = 8'h80;
  localparam logic [7:0] OFS_Y    = 8'h84;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LWR,
    ST_LRA,
    ST_LRD,
    ST_SXP,
    ST_SYP,
    ST_ACK
  } fir_state_e;

endpackage

// File: rtl/axil_master_if.sv
// AXI-Lite master channel sequencing for the bridge: AW/W complete independently, AR then R.
// Valids/readies are registered and only raised while the owning FSM state is active.
module axil_master_if
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 32,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  fir_state_e             st,
  input  logic                   wr_start,
  input  logic                   rd_start,
  input  logic                   abort,
  input  logic [pADDR_WIDTH-1:0] addr,
  input  logic [pDATA_WIDTH-1:0] data,
  output logic                   awvalid,
  output logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   awready,
  output logic                   wvalid,
  output logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   wready,
  output logic                   arvalid,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   arready,
  output logic                   rready,
  input  logic                   rvalid,
  input  logic [pDATA_WIDTH-1:0] rdata,
  output logic                   wr_done,
  output logic                   ar_hs,
  output logic                   rd_done,
  output logic [pDATA_WIDTH-1:0] rd_data
);

  logic                   aw_vld_q, aw_vld_d, w_vld_q, w_vld_d;
  logic                   aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                   ar_vld_q, ar_vld_d, r_rdy_q, r_rdy_d;
  logic [pADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [pDATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                   aw_hs, w_hs, r_hs;

  assign aw_hs   = (st == ST_LWR) & aw_vld_q & awready;
  assign w_hs    = (st == ST_LWR) & w_vld_q & wready;
  assign ar_hs   = (st == ST_LRA) & ar_vld_q & arready;
  assign r_hs    = (st == ST_LRD) & r_rdy_q & rvalid;
  assign wr_done = (st == ST_LWR) & (aw_done_q | aw_hs) & (w_done_q | w_hs);
  // A read response arriving alongside the address handshake is taken directly.
  assign rd_done = r_hs | (ar_hs & rvalid);
  assign rd_data = rdata;

  always_comb begin
    aw_vld_d  = aw_vld_q;
    w_vld_d   = w_vld_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    ar_vld_d  = ar_vld_q;
    r_rdy_d   = r_rdy_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    if (wr_start) begin
      aw_vld_d  = 1'b1;
      w_vld_d   = 1'b1;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      awaddr_d  = addr;
      wdata_d   = data;
    end
    if (rd_start) begin
      ar_vld_d = 1'b1;
      araddr_d = addr;
    end
    if (aw_hs) begin
      aw_vld_d  = 1'b0;
      aw_done_d = 1'b1;
    end
    if (w_hs) begin
      w_vld_d  = 1'b0;
      w_done_d = 1'b1;
    end
    if (ar_hs) begin
      ar_vld_d = 1'b0;
      r_rdy_d  = ~rvalid;
    end
    if (r_hs) r_rdy_d = 1'b0;
    if (abort) begin
      aw_vld_d = 1'b0;
      w_vld_d  = 1'b0;
      ar_vld_d = 1'b0;
      r_rdy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_vld_q  <= 1'b0;
      w_vld_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ar_vld_q  <= 1'b0;
      r_rdy_q   <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
    end else begin
      aw_vld_q  <= aw_vld_d;
      w_vld_q   <= w_vld_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      ar_vld_q  <= ar_vld_d;
      r_rdy_q   <= r_rdy_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign awvalid = aw_vld_q;
  assign wvalid  = w_vld_q;
  assign arvalid = ar_vld_q;
  assign rready  = r_rdy_q;
  assign awaddr  = awaddr_q;
  assign araddr  = araddr_q;
  assign wdata   = wdata_q;

endmodule

// File: rtl/wb_fir_bridge.sv
// Wishbone slave mapping CPU accesses onto the FIR's AXI-Lite and X/Y streams.
// Every handshake is bounded by a timeout that error-acks with all-ones data and a sticky flag.
module wb_fir_bridge
  import fir_pkg::*;
#(
  parameter int                     pADDR_WIDTH = 32,
  parameter int                     pDATA_WIDTH = 32,
  parameter logic [pADDR_WIDTH-1:0] pBASE       = FIR_BASE,
  parameter int                     pTIMEOUT    = 255
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  input  logic                   wb_we_i,
  input  logic [3:0]             wb_sel_i,
  input  logic [pADDR_WIDTH-1:0] wb_adr_i,
  input  logic [pDATA_WIDTH-1:0] wb_dat_i,
  output logic                   wb_ack_o,
  output logic [pDATA_WIDTH-1:0] wb_dat_o,
  output logic                   awvalid,
  output logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   awready,
  output logic                   wvalid,
  output logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   wready,
  output logic                   arvalid,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   arready,
  output logic                   rready,
  input  logic                   rvalid,
  input  logic [pDATA_WIDTH-1:0] rdata,
  output logic                   ss_tvalid,
  output logic [pDATA_WIDTH-1:0] ss_tdata,
  output logic                   ss_tlast,
  input  logic                   ss_tready,
  output logic                   sm_tready,
  input  logic                   sm_tvalid,
  input  logic [pDATA_WIDTH-1:0] sm_tdata,
  input  logic                   sm_tlast,
  output logic                   err_o
);

  localparam logic [8:0] TMO_MAX = 9'(pTIMEOUT);

  fir_state_e             state_q, state_d;
  logic [7:0]             ofs_q, ofs_d;
  logic [pDATA_WIDTH-1:0] dat_q, dat_d;
  logic [8:0]             tmo_q, tmo_d;
  logic [31:0]            len_q, len_d, x_cnt_q, x_cnt_d;
  logic                   ss_vld_q, ss_vld_d, ss_last_q, ss_last_d, sm_rdy_q, sm_rdy_d;
  logic [pDATA_WIDTH-1:0] ss_dat_q, ss_dat_d, rdat_q, rdat_d;
  logic                   ack_q, ack_d, err_q, err_d;

  logic hit, is_x, is_y, busy, tmo_hit, fail;
  logic wr_start, rd_start, wr_done, ar_hs, rd_done;
  logic [pDATA_WIDTH-1:0] rd_data;
  logic unused_sigs;

  assign unused_sigs = ^{wb_sel_i, sm_tlast};

  assign hit  = wb_cyc_i & wb_stb_i & (wb_adr_i[pADDR_WIDTH-1:8] == pBASE[pADDR_WIDTH-1:8]);
  assign is_x = wb_we_i & (wb_adr_i[7:0] == OFS_X);
  assign is_y = ~wb_we_i & (wb_adr_i[7:0] == OFS_Y);
  assign busy = (state_q == ST_LWR) | (state_q == ST_LRA) | (state_q == ST_LRD) |
                (state_q == ST_SXP) | (state_q == ST_SYP);
  assign tmo_hit = (tmo_q == TMO_MAX);

  always_comb begin
    state_d   = state_q;
    ofs_d     = ofs_q;
    dat_d     = dat_q;
    tmo_d     = tmo_q;
    len_d     = len_q;
    x_cnt_d   = x_cnt_q;
    ss_vld_d  = ss_vld_q;
    ss_dat_d  = ss_dat_q;
    ss_last_d = ss_last_q;
    sm_rdy_d  = sm_rdy_q;
    ack_d     = 1'b0;
    rdat_d    = rdat_q;
    err_d     = err_q;
    wr_start  = 1'b0;
    rd_start  = 1'b0;
    fail      = 1'b0;
    if (busy) tmo_d = tmo_q + 9'd1;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          ofs_d = wb_adr_i[7:0];
          dat_d = wb_dat_i;
          tmo_d = '0;
          if (is_x) begin
            state_d   = ST_SXP;
            ss_vld_d  = 1'b1;
            ss_dat_d  = wb_dat_i;
            ss_last_d = (len_q != 32'd0) && (x_cnt_q == len_q - 32'd1);
          end else if (is_y) begin
            state_d  = ST_SYP;
            sm_rdy_d = 1'b1;
          end else if (wb_we_i) begin
            state_d  = ST_LWR;
            wr_start = 1'b1;
          end else begin
            state_d  = ST_LRA;
            rd_start = 1'b1;
          end
        end
      end
      ST_LWR: begin
        if (wr_done) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          // Snoop completed config writes so tlast can be generated locally.
          if (ofs_q == OFS_LEN) len_d = dat_q;
          if ((ofs_q == OFS_CTRL) && dat_q[0]) x_cnt_d = '0;
        end else if (tmo_hit) begin
          fail = 1'b1;
        end
      end
      ST_LRA: begin
        if (rd_done) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          rdat_d  = rd_data;
        end else if (ar_hs) begin
          state_d = ST_LRD;
        end else if (tmo_hit) begin
          fail = 1'b1;
        end
      end
      ST_LRD: begin
        if (rd_done) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          rdat_d  = rd_data;
        end else if (tmo_hit) begin
          fail = 1'b1;
        end
      end
      ST_SXP: begin
        if (ss_tready) begin
          state_d  = ST_ACK;
          ack_d    = 1'b1;
          ss_vld_d = 1'b0;
          x_cnt_d  = x_cnt_q + 32'd1;
        end else if (tmo_hit) begin
          fail = 1'b1;
        end
      end
      ST_SYP: begin
        if (sm_tvalid) begin
          state_d  = ST_ACK;
          ack_d    = 1'b1;
          sm_rdy_d = 1'b0;
          rdat_d   = sm_tdata;
        end else if (tmo_hit) begin
          fail = 1'b1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (fail) begin
      state_d  = ST_ACK;
      ack_d    = 1'b1;
      ss_vld_d = 1'b0;
      sm_rdy_d = 1'b0;
      rdat_d   = '1;
      err_d    = 1'b1;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      state_q   <= ST_IDLE;
      ofs_q     <= '0;
      dat_q     <= '0;
      tmo_q     <= '0;
      len_q     <= '0;
      x_cnt_q   <= '0;
      ss_vld_q  <= 1'b0;
      ss_dat_q  <= '0;
      ss_last_q <= 1'b0;
      sm_rdy_q  <= 1'b0;
      ack_q     <= 1'b0;
      rdat_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ofs_q     <= ofs_d;
      dat_q     <= dat_d;
      tmo_q     <= tmo_d;
      len_q     <= len_d;
      x_cnt_q   <= x_cnt_d;
      ss_vld_q  <= ss_vld_d;
      ss_dat_q  <= ss_dat_d;
      ss_last_q <= ss_last_d;
      sm_rdy_q  <= sm_rdy_d;
      ack_q     <= ack_d;
      rdat_q    <= rdat_d;
      err_q     <= err_d;
    end
  end

  axil_master_if #(
    .pADDR_WIDTH (pADDR_WIDTH),
    .pDATA_WIDTH (pDATA_WIDTH)
  ) u_axil (
    .clk      (axis_clk),
    .rst_n    (axis_rst_n),
    .st       (state_q),
    .wr_start (wr_start),
    .rd_start (rd_start),
    .abort    (fail),
    .addr     (wb_adr_i),
    .data     (wb_dat_i),
    .awvalid  (awvalid),
    .awaddr   (awaddr),
    .awready  (awready),
    .wvalid   (wvalid),
    .wdata    (wdata),
    .wready   (wready),
    .arvalid  (arvalid),
    .araddr   (araddr),
    .arready  (arready),
    .rready   (rready),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .wr_done  (wr_done),
    .ar_hs    (ar_hs),
    .rd_done  (rd_done),
    .rd_data  (rd_data)
  );

  // An abandoned Wishbone cycle still finishes on the AXI side but gets no ack.
  assign wb_ack_o  = ack_q & wb_cyc_i;
  assign wb_dat_o  = rdat_q;
  assign err_o     = err_q;
  assign ss_tvalid = ss_vld_q;
  assign ss_tdata  = ss_dat_q;
  assign ss_tlast  = ss_last_q;
  assign sm_tready = sm_rdy_q;

endmodule

// File: tb/tb_wb_fir_bridge.sv
// Directed bench for wb_fir_bridge: Wishbone master plus cycle-scheduled FIR responder.
module tb_wb_fir_bridge;

  logic        axis_clk, axis_rst_n;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic        wb_ack_o;
  logic        awvalid, wvalid, awready, wready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        arvalid, arready, rready, rvalid;
  logic        ss_tvalid, ss_tlast, ss_tready;
  logic [31:0] ss_tdata, sm_tdata;
  logic        sm_tready, sm_tvalid, sm_tlast;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  int          r_ack_n, r_acks, r_aw, r_w, r_ar, r_rhs, r_ss, r_sm;
  logic [31:0] r_rd, r_addr, r_wdata, r_sdata;
  logic        r_last;

  wb_fir_bridge dut (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_we_i    (wb_we_i),
    .wb_sel_i   (wb_sel_i),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_o   (wb_ack_o),
    .wb_dat_o   (wb_dat_o),
    .awvalid    (awvalid),
    .awaddr     (awaddr),
    .awready    (awready),
    .wvalid     (wvalid),
    .wdata      (wdata),
    .wready     (wready),
    .arvalid    (arvalid),
    .araddr     (araddr),
    .arready    (arready),
    .rready     (rready),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .ss_tvalid  (ss_tvalid),
    .ss_tdata   (ss_tdata),
    .ss_tlast   (ss_tlast),
    .ss_tready  (ss_tready),
    .sm_tready  (sm_tready),
    .sm_tvalid  (sm_tvalid),
    .sm_tdata   (sm_tdata),
    .sm_tlast   (sm_tlast),
    .err_o      (err_o)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_rsp();
    awready = 0; wready = 0; arready = 0; rvalid = 0; ss_tready = 0; sm_tvalid = 0;
  endtask

  // Issue one Wishbone access. Each *_at is the clock edge (1 = hit edge) at which that
  // ready/valid is presented for exactly one cycle; 0 means never. r_ack_n is the edge
  // after which wb_ack_o is first seen (-1 if never).
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input int aw_at, input int w_at, input int ar_at, input int r_at,
                      input int ss_at, input int sm_at, input logic [31:0] rsp);
    bit done;
    r_ack_n = -1; r_acks = 0; r_aw = 0; r_w = 0; r_ar = 0; r_rhs = 0; r_ss = 0; r_sm = 0;
    r_rd = '0; r_addr = '0; r_wdata = '0; r_sdata = '0; r_last = 0;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
    rdata = rsp; sm_tdata = rsp;
    done = 0;
    for (int n = 1; n <= 400 && !done; n++) begin
      @(posedge axis_clk); #1;
      if (wb_ack_o) begin
        r_acks++;
        if (r_ack_n < 0) begin
          r_ack_n = n;
          r_rd = wb_dat_o;
        end
      end
      if (r_ack_n >= 0) begin
        wb_cyc_i = 0; wb_stb_i = 0;
      end
      awready   = (n == aw_at - 1);
      wready    = (n == w_at - 1);
      arready   = (n == ar_at - 1);
      rvalid    = (n == r_at - 1);
      ss_tready = (n == ss_at - 1);
      sm_tvalid = (n == sm_at - 1);
      if (awvalid && awready) begin r_aw++; r_addr = awaddr; end
      if (wvalid && wready) begin r_w++; r_wdata = wdata; end
      if (arvalid && arready) begin r_ar++; r_addr = araddr; end
      if (rready && rvalid) r_rhs++;
      if (ss_tvalid && ss_tready) begin r_ss++; r_sdata = ss_tdata; r_last = ss_tlast; end
      if (sm_tready && sm_tvalid) r_sm++;
      if (r_ack_n >= 0 && n >= r_ack_n + 3) done = 1;
    end
    wb_cyc_i = 0; wb_stb_i = 0;
    clear_rsp();
  endtask

  task automatic test_reset();
    checks++;
    if ({wb_ack_o, err_o, awvalid, wvalid, arvalid, rready, ss_tvalid, sm_tready, ss_tlast} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0", {wb_ack_o, err_o, awvalid, wvalid, arvalid, rready, ss_tvalid, sm_tready, ss_tlast});
    end
    checks++;
    if ({wb_dat_o, awaddr, araddr, wdata, ss_tdata} !== 160'b0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", {wb_dat_o, awaddr, araddr, wdata, ss_tdata});
    end
  endtask

  task automatic test_lite_write();
    // W accepted at edge 2, AW one cycle later at edge 3 -> ack after edge 3.
    xfer(1, 32'h3000_0040, 32'h0000_0005, 3, 2, 0, 0, 0, 0, 0);
    checks++;
    if (r_aw !== 1 || r_w !== 1) begin
      errors++; $display("FAIL wr_handshakes: got aw=%0d w=%0d want 1 1", r_aw, r_w);
    end
    checks++;
    if (r_addr !== 32'h3000_0040 || r_wdata !== 32'h5) begin
      errors++; $display("FAIL wr_addr_data: got %h/%h want 30000040/00000005", r_addr, r_wdata);
    end
    checks++;
    if (r_ack_n !== 3 || r_acks !== 1) begin
      errors++; $display("FAIL wr_ack: got edge=%0d count=%0d want 3 1", r_ack_n, r_acks);
    end
    // Both ready on the first valid cycle: minimum latency.
    xfer(1, 32'h3000_0044, 32'h0000_0006, 2, 2, 0, 0, 0, 0, 0);
    checks++;
    if (r_ack_n !== 2) begin
      errors++; $display("FAIL wr_min_latency: got %0d want 2", r_ack_n);
    end
  endtask

  task automatic test_lite_read();
    xfer(0, 32'h3000_0000, 0, 0, 0, 2, 3, 0, 0, 32'h0000_0004);
    checks++;
    if (r_rd !== 32'h4 || r_ack_n !== 3) begin
      errors++; $display("FAIL rd_basic: got dat=%h edge=%0d want 00000004 3", r_rd, r_ack_n);
    end
    checks++;
    if (r_ar !== 1 || r_rhs !== 1 || r_addr !== 32'h3000_0000) begin
      errors++; $display("FAIL rd_handshakes: got ar=%0d r=%0d addr=%h want 1 1 30000000", r_ar, r_rhs, r_addr);
    end
    // rvalid together with arready skips the data-wait state.
    xfer(0, 32'h3000_0080, 0, 0, 0, 2, 2, 0, 0, 32'hA5A5_0001);
    checks++;
    if (r_rd !== 32'hA5A5_0001 || r_ack_n !== 2 || r_ar !== 1) begin
      errors++; $display("FAIL rd_same_cycle: got dat=%h edge=%0d ar=%0d want a5a50001 2 1", r_rd, r_ack_n, r_ar);
    end
  endtask

  task automatic test_no_hit();
    xfer(1, 32'h3000_0140, 32'h1, 2, 2, 0, 0, 2, 0, 0);
    checks++;
    if (r_ack_n !== -1 || r_aw !== 0 || r_ss !== 0) begin
      errors++; $display("FAIL no_hit: got ack=%0d aw=%0d ss=%0d want -1 0 0", r_ack_n, r_aw, r_ss);
    end
  endtask

  task automatic test_stream_x();
    logic exp_last;
    // len is still 0 here: tlast must stay low.
    xfer(1, 32'h3000_0080, 32'd7, 0, 0, 0, 0, 2, 0, 0);
    checks++;
    if (r_last !== 0 || r_sdata !== 32'd7 || r_ack_n !== 2) begin
      errors++; $display("FAIL push_len0: got last=%b dat=%0d edge=%0d want 0 7 2", r_last, r_sdata, r_ack_n);
    end
    xfer(1, 32'h3000_0010, 32'd3, 2, 2, 0, 0, 0, 0, 0);
    for (int round = 0; round < 2; round++) begin
      xfer(1, 32'h3000_0000, 32'h1, 2, 2, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 4; i++) begin
        xfer(1, 32'h3000_0080, 32'(i + 10 * round), 0, 0, 0, 0, 2, 0, 0);
        exp_last = (i == 3);
        checks++;
        if (r_last !== exp_last || r_sdata !== 32'(i + 10 * round) || r_ss !== 1) begin
          errors++;
          $display("FAIL push_r%0d_%0d: got last=%b dat=%0d hs=%0d want %b %0d 1",
                   round, i, r_last, r_sdata, r_ss, exp_last, i + 10 * round);
        end
      end
    end
  endtask

  task automatic test_stream_y();
    xfer(0, 32'h3000_0084, 0, 0, 0, 0, 0, 0, 22, 32'd42);
    checks++;
    if (r_rd !== 32'd42 || r_ack_n !== 22 || r_sm !== 1) begin
      errors++; $display("FAIL pop_delayed: got dat=%0d edge=%0d hs=%0d want 42 22 1", r_rd, r_ack_n, r_sm);
    end
  endtask

  task automatic test_timeout();
    xfer(1, 32'h3000_0080, 32'd9, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (r_ack_n < 255 || r_ack_n > 258 || r_acks !== 1) begin
      errors++; $display("FAIL tmo_ack: got edge=%0d count=%0d want 255..258 1", r_ack_n, r_acks);
    end
    checks++;
    if (r_rd !== 32'hFFFF_FFFF || err_o !== 1'b1 || ss_tvalid !== 1'b0) begin
      errors++; $display("FAIL tmo_result: got dat=%h err=%b tvalid=%b want ffffffff 1 0", r_rd, err_o, ss_tvalid);
    end
    xfer(1, 32'h3000_0020, 32'h2, 2, 2, 0, 0, 0, 0, 0);
    checks++;
    if (err_o !== 1'b1 || r_ack_n !== 2) begin
      errors++; $display("FAIL tmo_sticky: got err=%b edge=%0d want 1 2", err_o, r_ack_n);
    end
  endtask

  task automatic test_reset_in_lra();
    int acks = 0;
    clear_rsp();
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 32'h3000_0004;
    @(posedge axis_clk); #1;
    checks++;
    if (arvalid !== 1'b1) begin
      errors++; $display("FAIL lra_entry: got arvalid=%b want 1", arvalid);
    end
    axis_rst_n = 0;
    @(posedge axis_clk); #1;
    checks++;
    if (arvalid !== 1'b0 || wb_ack_o !== 1'b0 || err_o !== 1'b0) begin
      errors++; $display("FAIL lra_reset: got arvalid=%b ack=%b err=%b want 0 0 0", arvalid, wb_ack_o, err_o);
    end
    axis_rst_n = 1;
    wb_cyc_i = 0; wb_stb_i = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge axis_clk); #1;
      if (wb_ack_o || arvalid) acks++;
    end
    checks++;
    if (acks !== 0) begin
      errors++; $display("FAIL lra_quiet: got %0d stray cycles want 0", acks);
    end
    xfer(0, 32'h3000_0008, 0, 0, 0, 2, 3, 0, 0, 32'h0000_0055);
    checks++;
    if (r_rd !== 32'h55 || r_ack_n !== 3) begin
      errors++; $display("FAIL lra_recover: got dat=%h edge=%0d want 00000055 3", r_rd, r_ack_n);
    end
  endtask

  initial begin
    axis_rst_n = 0;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_sel_i = 4'hF;
    wb_adr_i = '0; wb_dat_i = '0;
    rdata = '0; sm_tdata = '0; sm_tlast = 0;
    clear_rsp();
    repeat (3) @(posedge axis_clk);
    #1;
    test_reset();
    axis_rst_n = 1;
    test_lite_write();
    test_lite_read();
    test_no_hit();
    test_stream_x();
    test_stream_y();
    test_timeout();
    test_reset_in_lra();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
